mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Parametrised iterative multiply/divide unit that owns the architectural HI/LO pair.
//  It replaces the single-cycle HI_Reg/LO_Reg + ALU product path in the EX stage.
//  Handles MULT/MULTU/DIV/DIVU/MADD/MSUB/MTHI/MTLO over WIDTH-bit operands.
//  Asserts Busy so the hazard logic can stall EX. Supports pipeline flush (abort).
// PARAMETERS
//  WIDTH   32   operand width; HI and LO are each WIDTH bits
//  CNT_W   6    iteration-counter width; must be >= clog2(WIDTH+1)
// PORTS
//  Clk     in   1        clock; all state changes on the rising edge
//  Rst     in   1        synchronous, active-high reset
//  Start   in   1        launch Op with A/B; sampled only in IDLE
//  Op      in   3        0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MSUB, 6 MTHI, 7 MTLO
//  A       in   WIDTH    rs operand (dividend / multiplicand / MTHI-MTLO source)
//  B       in   WIDTH    rt operand (divisor / multiplier)
//  Flush   in   1        abort the in-flight op; HI/LO untouched
//  Busy    out  1        high while state != IDLE; pipeline stalls on Busy
//  Done    out  1        one-cycle pulse; the cycle HI/LO first show the new result
//  HI      out  WIDTH    architectural HI (drives MFHI)
//  LO      out  WIDTH    architectural LO (drives MFLO)
// BEHAVIOUR
//  Reset: state=IDLE. HI=LO=0, Busy=0, Done=0. Counter and scratch registers cleared.
//   Rst mid-operation aborts the op with no write; Rst has priority over Flush and Start.
//  States: IDLE -> CALC -> FIX -> IDLE.
//  IDLE + Start + Op<=5: latch |A|, |B| (abs only for signed ops), sign flags and Op.
//   cnt=0, go to CALC.
//  IDLE + Start + MTHI/MTLO: HI (or LO) <= A at that edge. Stay in IDLE, Busy stays 0.
//   Done pulses in the next cycle.
//  CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
//   Runs exactly WIDTH cycles (cnt 0..WIDTH-1), then goes to FIX.
//  FIX, one cycle:
//   - apply signs: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
//   - MADD/MSUB: {HI,LO} +/- the 2*WIDTH-bit product, modulo 2^(2*WIDTH).
//   - write HI/LO and go to IDLE. Done=1 in the following cycle.
//  Latency: Start at cycle t -> Done high and HI/LO valid at cycle t+WIDTH+2.
//   Busy is high in cycles t+1 .. t+WIDTH+1.
//  Result placement: MULT* gives HI=upper, LO=lower half. DIV* gives LO=quotient, HI=remainder.
//  Divide by zero: LO=all ones, HI=A (raw dividend). Full WIDTH cycles still elapse.
//  Signed overflow (min / -1): LO=min, HI=0. This falls out of the magnitude arithmetic.
//  Start while Busy is ignored; the hazard unit must hold the instruction.
//  Flush in CALC or FIX (at or before the FIX edge): next state IDLE, no HI/LO write, no Done.
//  Flush in IDLE is ignored, and a simultaneous Start is still honoured.
//  HI/LO change only on FIX writes, MTHI/MTLO and Rst.
//  All arithmetic is unsigned on the magnitudes, with WIDTH+1-bit subtract for divide.
// STRUCTURE
//  Shared package mdu_pkg:
//   - Op encodings: MDU_MULT .. MDU_MTLO.
//   - State encodings: S_IDLE, S_CALC, S_FIX.
//   - Constant MDU_OP_W=3.
//   The Controller emits these Op codes in place of the HiLoWrite bits.
//  One sub-module: mdu_div_step. Combinational restoring step:
//   {rem,quo}, divisor -> next {rem,quo}. Reused each CALC cycle.
//  Multiply step, counter and FSM stay inline.
// TESTING (WIDTH=32 unless noted)
//  1 MULT A=0xFFFFFFFD(-3) B=7 -> Done at t+34; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
//    Busy high exactly 33 cycles.
//  2 MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
//    Then MADD A=2 B=3 -> HI=0xFFFFFFFE, LO=0x00000007.
//  3 DIV A=-7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//    DIVU A=7 B=0 -> LO=0xFFFFFFFF, HI=0x00000007.
//    DIV 0x80000000 by -1 -> LO=0x80000000, HI=0.
//  4 MTHI A=0x12345678 -> HI updated at the next edge with Busy=0; Done pulses one cycle.
//    Then MSUB A=1 B=1 from HI=0x12345678, LO=0 -> HI=0x12345677, LO=0xFFFFFFFF.
//  5 DIV started; Flush at t+10 -> Busy=0 at t+11; HI/LO unchanged; Done never pulses.
//    A second Start at t+5 is ignored.
//  6 Rst at t+20 mid-MULT -> HI=LO=0, Busy=Done=0 next cycle. Repeat with WIDTH=8, CNT_W=4:
//    MULT 0x80*0x80 -> HI=0x40, LO=0x00, Done at t+10.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - Op encodings sent by the controller (MDU_MULT .. MDU_MTLO)
//   - FSM state encodings (S_IDLE, S_CALC, S_FIX)
//   - Small decode helpers used by the datapath and the FSM
package mdu_pkg;

   localparam int MDU_OP_W = 3;

   typedef enum logic [MDU_OP_W-1:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MADD  = 3'd4,
      MDU_MSUB  = 3'd5,
      MDU_MTHI  = 3'd6,
      MDU_MTLO  = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } mdu_state_e;

   // MADD/MSUB accumulate a signed product.
   function automatic logic op_is_signed(input logic [MDU_OP_W-1:0] op);
      return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD) || (op == MDU_MSUB);
   endfunction

   function automatic logic op_is_div(input logic [MDU_OP_W-1:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   // Register moves complete in IDLE without entering the iterative path.
   function automatic logic op_is_move(input logic [MDU_OP_W-1:0] op);
      return (op == MDU_MTHI) || (op == MDU_MTLO);
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring division step, purely combinational.
// Ports:
//   rq_i      {remainder, quotient} before the step (2*WIDTH bits)
//   divisor_i divisor magnitude (WIDTH bits)
//   rq_o      {remainder, quotient} after the step
// The quotient half doubles as the dividend shift register: its MSB is
// shifted into the remainder and the new quotient bit enters at the LSB.
module mdu_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] rq_i,
   input  logic [WIDTH-1:0]   divisor_i,
   output logic [2*WIDTH-1:0] rq_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   assign shifted = rq_i[2*WIDTH-1:WIDTH-1];
   assign diff    = shifted - {1'b0, divisor_i};

   // diff[WIDTH] set means the trial subtract went negative: restore.
   assign rq_o = diff[WIDTH] ? {shifted[WIDTH-1:0], rq_i[WIDTH-2:0], 1'b0}
                             : {diff[WIDTH-1:0],    rq_i[WIDTH-2:0], 1'b1};

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair.
// Ports:
//   Clk, Rst   clock, synchronous active-high reset
//   Start/Op   launch an operation (sampled only in IDLE)
//   A, B       rs / rt operands
//   Flush      abort the in-flight operation, HI/LO untouched
//   Busy       high while not IDLE (pipeline stall)
//   Done       one-cycle pulse when HI/LO first show a new result
//   HI, LO     architectural HI/LO
// Handshake: Start is accepted only when Busy is low; an accepted
// multiply/divide raises Busy for WIDTH+1 cycles and then pulses Done
// (unless flushed or reset). MTHI/MTLO never raise Busy; Done pulses the
// following cycle. The FSM state is held in state_q.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                Start,
   input  logic [MDU_OP_W-1:0] Op,
   input  logic [WIDTH-1:0]    A,
   input  logic [WIDTH-1:0]    B,
   input  logic                Flush,
   output logic                Busy,
   output logic                Done,
   output logic [WIDTH-1:0]    HI,
   output logic [WIDTH-1:0]    LO
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   mdu_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [MDU_OP_W-1:0] op_q, op_d;
   logic                sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
   logic [2*WIDTH-1:0]  prod_q, prod_d;
   logic [WIDTH-1:0]    opnd_q, opnd_d;
   logic [WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d;
   logic                done_q, done_d;

   // Operand magnitudes at launch.
   logic             in_signed, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign in_signed = op_is_signed(Op);
   assign a_neg     = in_signed & A[WIDTH-1];
   assign b_neg     = in_signed & B[WIDTH-1];
   assign a_mag     = a_neg ? -A : A;
   assign b_mag     = b_neg ? -B : B;

   // Multiply step: prod_q = {partial product, remaining multiplier bits}.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next, div_next;

   assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (prod_q[0] ? opnd_q : {WIDTH{1'b0}})};
   assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

   // Divide step: prod_q = {remainder, quotient/dividend}.
   mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rq_i      (prod_q),
      .divisor_i (opnd_q),
      .rq_o      (div_next)
   );

   // Sign fix-up and accumulate, used in FIX.
   logic               res_neg;
   logic [2*WIDTH-1:0] prod_s, hilo, mac;
   logic [WIDTH-1:0]   quo_s, rem_s;

   assign res_neg = sa_q ^ sb_q;
   assign prod_s  = res_neg ? -prod_q : prod_q;
   assign hilo    = {hi_q, lo_q};
   assign mac     = (op_q == MDU_MSUB) ? (hilo - prod_s) : (hilo + prod_s);
   assign quo_s   = res_neg ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
   assign rem_s   = sa_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

   // State register (plus datapath flops).
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         bz_q    <= 1'b0;
         prod_q  <= '0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         bz_q    <= bz_d;
         prod_q  <= prod_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (Start && !op_is_move(Op)) state_d = S_CALC;
         S_CALC: begin
            if (Flush)                  state_d = S_IDLE;
            else if (cnt_q == LAST_CNT) state_d = S_FIX;
         end
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values.
   always_comb begin
      cnt_d  = cnt_q;
      op_d   = op_q;
      sa_d   = sa_q;
      sb_d   = sb_q;
      bz_d   = bz_q;
      prod_d = prod_q;
      opnd_d = opnd_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               if (Op == MDU_MTHI) begin
                  hi_d   = A;
                  done_d = 1'b1;
               end else if (Op == MDU_MTLO) begin
                  lo_d   = A;
                  done_d = 1'b1;
               end else begin
                  op_d  = Op;
                  sa_d  = a_neg;
                  sb_d  = b_neg;
                  bz_d  = (B == {WIDTH{1'b0}});
                  cnt_d = '0;
                  if (op_is_div(Op)) begin
                     prod_d = {{WIDTH{1'b0}}, a_mag};
                     opnd_d = b_mag;
                  end else begin
                     prod_d = {{WIDTH{1'b0}}, b_mag};
                     opnd_d = a_mag;
                  end
               end
            end
         end
         S_CALC: begin
            prod_d = op_is_div(op_q) ? div_next : mul_next;
            cnt_d  = cnt_q + CNT_W'(1);
         end
         S_FIX: begin
            if (!Flush) begin
               done_d = 1'b1;
               if (op_is_div(op_q)) begin
                  // Divide by zero: quotient all ones, remainder is the raw dividend.
                  lo_d = bz_q ? {WIDTH{1'b1}} : quo_s;
                  hi_d = rem_s;
               end else if ((op_q == MDU_MADD) || (op_q == MDU_MSUB)) begin
                  {hi_d, lo_d} = mac;
               end else begin
                  {hi_d, lo_d} = prod_s;
               end
            end
         end
         default: ;
      endcase
   end

   // Outputs.
   always_comb begin
      Busy = (state_q != S_IDLE);
      Done = done_q;
      HI   = hi_q;
      LO   = lo_q;
   end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

   localparam int W = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          Rst, Start, Flush;
   logic [2:0]    Op;
   logic [W-1:0]  A, B;
   logic          Busy, Done;
   logic [W-1:0]  HI, LO;

   logic          rst8, start8, flush8;
   logic [2:0]    op8;
   logic [7:0]    a8, b8;
   logic          busy8, done8;
   logic [7:0]    hi8, lo8;

   mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .Clk(clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B), .Flush(Flush),
      .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
   );

   mul_div_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
      .Clk(clk), .Rst(rst8), .Start(start8), .Op(op8), .A(a8), .B(b8), .Flush(flush8),
      .Busy(busy8), .Done(done8), .HI(hi8), .LO(lo8)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Result of an operation from plain integer arithmetic: {HI, LO}.
   function automatic logic [63:0] model_calc(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] hi,
                                              input logic [31:0] lo);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, acc;
      logic [63:0]     res;
      sa  = $signed(a);
      sb  = $signed(b);
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      acc = {hi, lo};
      res = {hi, lo};
      case (op)
         3'd0: res = sa * sb;
         3'd1: res = ua * ub;
         3'd2: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin
               q   = sa / sb;
               r   = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         3'd3: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin
               q   = longint'(ua / ub);
               r   = longint'(ua % ub);
               res = {r[31:0], q[31:0]};
            end
         end
         3'd4: res = acc + longint'(sa * sb);
         3'd5: res = acc - longint'(sa * sb);
         default: res = {hi, lo};
      endcase
      return res;
   endfunction

   // Architectural HI/LO plus a countdown of remaining busy cycles.
   logic [W-1:0]   m_hi = '0, m_lo = '0;
   int             m_left = 0;
   logic           m_done = 1'b0;
   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] m_res;

   always @(posedge clk) begin
      if (Rst) begin
         m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
         exp_q.delete();
      end else if (m_left > 0) begin
         m_done = 1'b0;
         if (Flush) begin
            m_left = 0;
            exp_q.delete();
         end else begin
            m_left--;
            if (m_left == 0 && exp_q.size() > 0) begin
               m_res  = exp_q.pop_front();
               m_hi   = m_res[63:32];
               m_lo   = m_res[31:0];
               m_done = 1'b1;
            end
         end
      end else begin
         m_done = 1'b0;
         if (Start) begin
            if (Op == 3'd6) begin
               m_hi = A; m_done = 1'b1;
            end else if (Op == 3'd7) begin
               m_lo = A; m_done = 1'b1;
            end else begin
               exp_q.push_back(model_calc(Op, A, B, m_hi, m_lo));
               m_left = W + 1;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check($sformatf("cyc%0d_busy", cyc), 64'(Busy), 64'(m_left > 0));
         check($sformatf("cyc%0d_done", cyc), 64'(Done), 64'(m_done));
         check($sformatf("cyc%0d_hi", cyc), 64'(HI), 64'(m_hi));
         check($sformatf("cyc%0d_lo", cyc), 64'(LO), 64'(m_lo));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit flush_start, input int flush_at, input int restart_at,
                         input int rst_at, output int busy_n, output int done_off,
                         output int done_n, output logic [63:0] trace);
      @(posedge clk); #1;
      Start = 1'b1; Op = op; A = a; B = b; Flush = flush_start;
      @(posedge clk); #1;
      Start = 1'b0; Flush = 1'b0;
      busy_n = 0; done_off = -1; done_n = 0; trace = '0;
      for (int k = 1; k <= 40; k++) begin
         Flush = (k == flush_at);
         Rst   = (k == rst_at);
         Start = (k == restart_at);
         if (k == restart_at) Op = 3'd0;
         @(negedge clk);
         if (Busy) begin busy_n++; trace[k] = 1'b1; end
         if (Done) begin done_n++; if (done_off < 0) done_off = k; end
         @(posedge clk); #1;
      end
      Flush = 1'b0; Rst = 1'b0; Start = 1'b0;
   endtask

   task automatic simple_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int done_off);
      int bn, dn;
      logic [63:0] tr;
      run_op(op, a, b, 1'b0, 0, 0, 0, bn, done_off, dn, tr);
   endtask

   task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int done_off);
      @(posedge clk); #1;
      start8 = 1'b1; op8 = op; a8 = a; b8 = b;
      @(posedge clk); #1;
      start8 = 1'b0; done_off = -1;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (done8 && done_off < 0) done_off = k;
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int bn, doff, dn;
      logic [63:0] tr;
      Rst = 1'b1; Start = 1'b0; Flush = 1'b0; Op = '0; A = '0; B = '0;
      rst8 = 1'b1; start8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      Rst = 1'b0; rst8 = 1'b0;
      @(negedge clk);
      check("reset_hi", 64'(HI), 64'd0);
      check("reset_lo", 64'(LO), 64'd0);
      check("reset_busy", 64'(Busy), 64'd0);
      check("reset_done", 64'(Done), 64'd0);

      // MULT -3 * 7
      run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 0, 0, 0, bn, doff, dn, tr);
      check("mult_busy_cycles", 64'(bn), 64'd33);
      check("mult_done_off", 64'(doff), 64'd34);
      check("mult_done_pulses", 64'(dn), 64'd1);
      check("mult_hi", 64'(HI), 64'hFFFF_FFFF);
      check("mult_lo", 64'(LO), 64'hFFFF_FFEB);

      // MULTU then MADD
      simple_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, doff);
      check("multu_hi", 64'(HI), 64'hFFFF_FFFE);
      check("multu_lo", 64'(LO), 64'h0000_0001);
      simple_op(3'd4, 32'd2, 32'd3, doff);
      check("madd_hi", 64'(HI), 64'hFFFF_FFFE);
      check("madd_lo", 64'(LO), 64'h0000_0007);

      // Divides
      simple_op(3'd2, 32'hFFFF_FFF9, 32'd2, doff);
      check("div_lo", 64'(LO), 64'hFFFF_FFFD);
      check("div_hi", 64'(HI), 64'hFFFF_FFFF);
      simple_op(3'd3, 32'd7, 32'd0, doff);
      check("divu0_done_off", 64'(doff), 64'd34);
      check("divu0_lo", 64'(LO), 64'hFFFF_FFFF);
      check("divu0_hi", 64'(HI), 64'h0000_0007);
      simple_op(3'd2, 32'hFFFF_FFF9, 32'd0, doff);
      check("div0_neg_lo", 64'(LO), 64'hFFFF_FFFF);
      check("div0_neg_hi", 64'(HI), 64'hFFFF_FFF9);
      simple_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, doff);
      check("div_ovf_lo", 64'(LO), 64'h8000_0000);
      check("div_ovf_hi", 64'(HI), 64'h0000_0000);

      // MTHI / MTLO / MSUB
      run_op(3'd6, 32'h1234_5678, 32'd0, 1'b0, 0, 0, 0, bn, doff, dn, tr);
      check("mthi_busy", 64'(bn), 64'd0);
      check("mthi_done_off", 64'(doff), 64'd1);
      check("mthi_done_pulses", 64'(dn), 64'd1);
      check("mthi_hi", 64'(HI), 64'h1234_5678);
      simple_op(3'd7, 32'd0, 32'd0, doff);
      check("mtlo_lo", 64'(LO), 64'd0);
      simple_op(3'd5, 32'd1, 32'd1, doff);
      check("msub_hi", 64'(HI), 64'h1234_5677);
      check("msub_lo", 64'(LO), 64'hFFFF_FFFF);

      // Flush mid-divide with an ignored second Start
      run_op(3'd2, 32'd100, 32'd7, 1'b0, 10, 5, 0, bn, doff, dn, tr);
      check("flush_busy_t10", 64'(tr[10]), 64'd1);
      check("flush_busy_t11", 64'(tr[11]), 64'd0);
      check("flush_busy_cycles", 64'(bn), 64'd10);
      check("flush_no_done", 64'(dn), 64'd0);
      check("flush_hi", 64'(HI), 64'h1234_5677);
      check("flush_lo", 64'(LO), 64'hFFFF_FFFF);

      // Flush in IDLE together with Start: Start honoured
      run_op(3'd3, 32'd100, 32'd7, 1'b1, 0, 0, 0, bn, doff, dn, tr);
      check("idle_flush_done_off", 64'(doff), 64'd34);
      check("idle_flush_lo", 64'(LO), 64'd14);
      check("idle_flush_hi", 64'(HI), 64'd2);

      // Reset mid-multiply
      run_op(3'd0, 32'd5, 32'd6, 1'b0, 0, 0, 20, bn, doff, dn, tr);
      check("rst_busy_t20", 64'(tr[20]), 64'd1);
      check("rst_busy_t21", 64'(tr[21]), 64'd0);
      check("rst_no_done", 64'(dn), 64'd0);
      check("rst_hi", 64'(HI), 64'd0);
      check("rst_lo", 64'(LO), 64'd0);

      // Randomized operations checked by the model
      for (int i = 0; i < 40; i++) begin
         logic [2:0] op;
         int fa, ra;
         op = 3'($urandom_range(0, 7));
         fa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 34)) : 0;
         ra = (op <= 3'd5 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
         run_op(op, pick_val(), pick_val(), 1'($urandom_range(0, 3) == 0), fa, ra, 0,
                bn, doff, dn, tr);
      end

      // Narrow instance
      run8(3'd0, 8'h80, 8'h80, doff);
      check("w8_mult_done_off", 64'(doff), 64'd10);
      check("w8_mult_hi", 64'(hi8), 64'h40);
      check("w8_mult_lo", 64'(lo8), 64'h00);
      run8(3'd2, 8'hF9, 8'h02, doff);
      check("w8_div_lo", 64'(lo8), 64'hFD);
      check("w8_div_hi", 64'(hi8), 64'hFF);
      run8(3'd1, 8'hFF, 8'hFF, doff);
      check("w8_multu_hi", 64'(hi8), 64'hFE);
      check("w8_multu_lo", 64'(lo8), 64'h01);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
